// File: rtl/prio_arbiter8.sv
// rtl/prio_arbiter8.sv - 8-way arbiter with held grants, hold-time limit and eviction mask.
// Optional rotating priority via `define PRIO_ARB_ROUND_ROBIN_EN; default build is fixed priority (7 highest).
module prio_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] mask;
    logic [7:0] cand;
    logic       win_found;
    logic [2:0] win_id;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [2:0] last_id;
    logic [2:0] idx;
`endif

    // The mask is non-zero only during RELEASE, so IDLE effectively sees raw req.
    assign cand = req & ~mask;

    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        idx = 3'd0;
        // Search descends from last_id-1 with wrap, making the previous winner lowest.
        for (int k = 0; k < 8; k++) begin
            idx = last_id - 3'd1 - 3'(k);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            mask      <= 8'd0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            last_id   <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    timeout <= 1'b0;
                    mask    <= 8'd0;
                    if (ena && win_found) begin
                        gnt       <= 8'd1 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= GRANT;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        last_id   <= win_id;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // Owner dropping its request wins over an expiring hold counter.
                    if (!req[gnt_id]) begin
                        state     <= RELEASE;
                        gnt       <= 8'd0;
                        gnt_id    <= 3'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state     <= RELEASE;
                        gnt       <= 8'd0;
                        gnt_id    <= 3'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        mask      <= 8'd1 << gnt_id;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 8'd0;
                    gnt_id    <= 3'd0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter8.sv
// tb/tb_prio_arbiter8.sv - directed self-checking bench for prio_arbiter8 (MAX_HOLD = 4).
module tb_prio_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    prio_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {gnt, gnt_id, gnt_valid, timeout} as one vector.
    task automatic chk(input string tag, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic t);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {gnt, gnt_id, gnt_valid, timeout};
        exp = {g, id, v, t};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed gnt/id/v/to=%h/%0d/%b/%b expected %h/%0d/%b/%b",
                   tag, obs[12:5], obs[4:2], obs[1], obs[0], g, id, v, t);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; req = 8'h00;
        step(); step();
        rst = 1'b0;
        chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // Basic grant latency and reset mid-grant
        ena = 1'b1; req = 8'h24;
        step(); chk("grant_24", 8'h20, 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        step(); chk("rst_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 8'h00;
        step(); chk("idle_after_rst", 8'h00, 3'd0, 1'b0, 1'b0);

        // Non-owner requests do not preempt; release gap then next winner
        req = 8'h24;
        step(); chk("grant5_again", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'hA4;
        step(); chk("no_preempt", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h84;
        step(); chk("release_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); chk("grant7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        step(); chk("release7", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); chk("idle_empty", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout after MAX_HOLD = 4 cycles, eviction mask
        req = 8'h08;
        step(); chk("hold_c1", 8'h08, 3'd3, 1'b1, 1'b0);
        step(); chk("hold_c2", 8'h08, 3'd3, 1'b1, 1'b0);
        step(); chk("hold_c3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h09;
        step(); chk("hold_c4", 8'h08, 3'd3, 1'b1, 1'b0);
        step(); chk("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        step(); chk("masked_winner0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h08;
        step(); chk("release0", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); chk("grant3_again", 8'h08, 3'd3, 1'b1, 1'b0);

        // Request drop coinciding with timeout: timeout stays low
        step(); step(); step();
        chk("hold3_c4", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        step(); chk("drop_beats_timeout", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); chk("idle_after_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Enable gating
        ena = 1'b0; req = 8'hFF;
        step(); step(); chk("ena_low_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        ena = 1'b1; req = 8'h10;
        step(); chk("grant4", 8'h10, 3'd4, 1'b1, 1'b0);
        ena = 1'b0;
        step(); chk("ena_low_keeps", 8'h10, 3'd4, 1'b1, 1'b0);
        req = 8'h00;
        step(); chk("release4", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h10;
        step(); chk("no_new_grant_a", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); chk("no_new_grant_b", 8'h00, 3'd0, 1'b0, 1'b0);

        // Priority rotation (or fixed priority) with owners releasing after 1 cycle
        rst = 1'b1; ena = 1'b1; req = 8'h00;
        step();
        rst = 1'b0; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e_id;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            e_id = 3'(7 - k);
`else
            e_id = 3'd7;
`endif
            step(); chk($sformatf("order_%0d", k), 8'd1 << e_id, e_id, 1'b1, 1'b0);
            req = 8'hFF & ~(8'd1 << e_id);
            step(); chk($sformatf("order_rel_%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
